// File: rtl/seq_divider.sv
// seq_divider: restoring shift/subtract divider, one trial subtraction per clock.
// Defining SIGNED_DIV_EN enables two's-complement operands with truncation toward zero.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH:0] sh, t;
  logic [WIDTH-1:0] p, p_n, q, q_n, d, mag_a, mag_b;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, ovp, cap_nq, cap_nr, cap_ov, accept, last;
  // the partial remainder always stays below the divisor, so WIDTH bits hold it
  always_comb begin
    accept = start && state != RUN;
    last = state == RUN && cnt == CW'(WIDTH - 1);
    sh = {p, q[WIDTH-1]};
    t = sh - {1'b0, d};
    p_n = t[WIDTH] ? sh[WIDTH-1:0] : t[WIDTH-1:0];
    q_n = {q[WIDTH-2:0], ~t[WIDTH]};
`ifdef SIGNED_DIV_EN
    mag_a = dividend[WIDTH-1] ? -dividend : dividend;
    mag_b = divisor[WIDTH-1] ? -divisor : divisor;
    cap_nq = dividend[WIDTH-1] ^ divisor[WIDTH-1];
    cap_nr = dividend[WIDTH-1];
    cap_ov = dividend == {1'b1, {(WIDTH-1){1'b0}}} && &divisor;
`else
    mag_a = dividend;
    mag_b = divisor;
    cap_nq = 1'b0;
    cap_nr = 1'b0;
    cap_ov = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (accept) state_n = divisor == '0 ? DONE : RUN;
    else if (state == DONE) state_n = IDLE;
    else if (last) state_n = DONE;
  end
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ovp <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      div_by_zero <= divisor == '0;
      ovf <= 1'b0;
      p <= '0;
      q <= mag_a;
      d <= mag_b;
      cnt <= '0;
      neg_q <= cap_nq;
      neg_r <= cap_nr;
      ovp <= cap_ov;
      if (divisor == '0) begin
        quotient <= '1;
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      p <= p_n;
      q <= q_n;
      cnt <= cnt + CW'(1);
      if (last) begin
        quotient <= neg_q ? -q_n : q_n;
        remainder <= neg_r ? -p_n : p_n;
        ovf <= ovp;
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table vectors, hand corner sequences and random ops against an arithmetic model.
module tb_seq_divider;
  localparam int W = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero, ovf;
  logic [W-1:0] quotient, remainder;
  int total = 0, bad = 0;
  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic z;
  } vec_t;
  vec_t tbl[8];
  always #5 clk = ~clk;
  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .ovf(ovf)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void model(input logic [W-1:0] a, b, output logic [W-1:0] q, r,
                                output logic z, o);
    int sa, sb;
    z = b == 0;
    o = 1'b0;
    q = '1;
    r = a;
    if (b != 0) begin
`ifdef SIGNED_DIV_EN
      sa = $signed(a);
      sb = $signed(b);
      if (sa == -(1 << (W - 1)) && sb == -1) begin
        q = a;
        r = '0;
        o = 1'b1;
      end else begin
        q = W'(sa / sb);
        r = W'(sa % sb);
      end
`else
      sa = int'(a);
      sb = int'(b);
      q = W'(sa / sb);
      r = W'(sa % sb);
`endif
    end
  endfunction
  task automatic run(input logic [W-1:0] a, b, eq, er, input logic ez, eo, input bit glitch,
                     input string tag);
    int n, nb;
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
    n = 0;
    nb = 0;
    while (!done && n < 40) begin
      nb += int'(busy);
      if (glitch && n == 1) begin
        start = 1'b1;
        dividend = 2;
        divisor = 1;
      end else start = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk({tag, " latency"}, n, b == 0 ? 0 : W);
    chk({tag, " busy_cycles"}, nb, b == 0 ? 0 : W);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, div_by_zero, ez);
    chk({tag, " ovf"}, ovf, eo);
  endtask
  task automatic op(input logic [W-1:0] a, b, input bit glitch, input string tag);
    logic [W-1:0] q, r;
    logic z, o;
    model(a, b, q, r, z, o);
    run(a, b, q, r, z, o, glitch, tag);
  endtask
  task automatic idle_hold(input string tag);
    logic [W-1:0] q0;
    q0 = quotient;
    @(posedge clk);
    #1;
    chk({tag, " done_pulse"}, done, 0);
    chk({tag, " q_held"}, quotient, q0);
  endtask
  initial begin
    int n;
    tbl[0] = '{4'd13, 4'd3, 4'd4, 4'd1, 1'b0};
    tbl[1] = '{4'd7, 4'd0, 4'hF, 4'd7, 1'b1};
    tbl[2] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0};
    tbl[3] = '{4'd5, 4'd7, 4'd0, 4'd5, 1'b0};
    tbl[4] = '{4'd0, 4'd5, 4'd0, 4'd0, 1'b0};
    tbl[5] = '{4'd15, 4'd15, 4'd1, 4'd0, 1'b0};
    tbl[6] = '{4'd14, 4'd4, 4'd3, 4'd2, 1'b0};
    tbl[7] = '{4'd0, 4'd0, 4'hF, 4'd0, 1'b1};
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset flags", {div_by_zero, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifndef SIGNED_DIV_EN
    for (int i = 0; i < 8; i++) begin
      run(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, 1'b0, 1'b0, $sformatf("tbl%0d", i));
      idle_hold($sformatf("tbl%0d", i));
    end
`endif
    op(15, 1, 1'b0, "b2b_first");
    op(5, 7, 1'b0, "b2b_second");
    idle_hold("b2b");
    dividend = 9;
    divisor = 2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort outputs", {quotient, remainder}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      n += int'(done);
    end
    chk("abort no_done", n, 0);
    op(9, 2, 1'b0, "after_abort");
    idle_hold("after_abort");
    op(14, 3, 1'b1, "start_in_run");
    idle_hold("start_in_run");
`ifdef SIGNED_DIV_EN
    run(4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0, 1'b0, "s_neg7_2");
    idle_hold("s_neg7_2");
    run(4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 1'b1, 1'b0, "s_ovf");
    run(4'h6, 4'h3, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, "s_ovf_clear");
`endif
    for (int i = 0; i < 40; i++) begin
      op(W'($urandom), W'($urandom), 1'b0, $sformatf("rnd%0d", i));
      if ($urandom_range(1) == 1) idle_hold($sformatf("rnd%0d", i));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
